// File: rtl/soc_system_sysid_ext.sv
// Extended system-ID Avalon-MM slave: fixed ID/timestamp, scratch register,
// capability word, parameterised user words and a prescaled uptime counter
// read coherently through a high-word shadow captured on low-word reads.
module soc_system_sysid_ext #(
   parameter logic [31:0]  ID_VALUE       = 32'hACD51302,
   parameter logic [31:0]  TIMESTAMP      = 32'h5279E721,
   parameter logic [31:0]  SCRATCH_RESET  = 32'h00000000,
   parameter int unsigned  NUM_USER_WORDS = 0,
   parameter logic [255:0] USER_WORDS     = 256'h0,
   parameter int unsigned  UPTIME_WIDTH   = 48,
   parameter int unsigned  PRESCALE       = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   output logic        readdatavalid
);

   localparam int unsigned    PS_W       = 16;
   localparam logic [PS_W-1:0] PS_LAST   = PS_W'(PRESCALE - 1);
   localparam logic [3:0]     A_ID       = 4'd0;
   localparam logic [3:0]     A_TS       = 4'd1;
   localparam logic [3:0]     A_SCRATCH  = 4'd2;
   localparam logic [3:0]     A_UP_LO    = 4'd3;
   localparam logic [3:0]     A_UP_HI    = 4'd4;
   localparam logic [3:0]     A_CONTROL  = 4'd5;
   localparam logic [3:0]     A_CAP      = 4'd6;
   localparam logic [31:0]    CAP_WORD   = {8'(NUM_USER_WORDS), 8'd4, 16'h0001};

   logic [31:0]             scratch;
   logic [UPTIME_WIDTH-1:0] count;
   logic [PS_W-1:0]         presc;
   logic [31:0]             shadow;
   logic                    freeze;

   logic                    rd_acc_c;
   logic                    ctrl_wr_c;
   logic                    clear_c;
   logic                    tick_c;
   logic [31:0]             rdata_c;

   // A simultaneous write takes priority and drops the read.
   assign rd_acc_c  = read & ~write;
   assign ctrl_wr_c = write & (address == A_CONTROL);
   assign clear_c   = ctrl_wr_c & writedata[0];
   assign tick_c    = (presc == PS_LAST);

   // Read-data multiplexer over the register map.
   always_comb begin
      rdata_c = 32'h0;
      case (address)
         A_ID:      rdata_c = ID_VALUE;
         A_TS:      rdata_c = TIMESTAMP;
         A_SCRATCH: rdata_c = scratch;
         A_UP_LO:   rdata_c = count[31:0];
         A_UP_HI:   rdata_c = shadow;
         A_CONTROL: rdata_c = {30'b0, freeze, 1'b0};
         A_CAP:     rdata_c = CAP_WORD;
         default: begin
            if (address[3] && (32'(address[2:0]) < NUM_USER_WORDS))
               rdata_c = USER_WORDS[{address[2:0], 5'b0} +: 32];
         end
      endcase
   end

   // Registered read response with fixed one-cycle latency.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         readdata      <= 32'h0;
         readdatavalid <= 1'b0;
      end else begin
         readdatavalid <= rd_acc_c;
         if (rd_acc_c)
            readdata <= rdata_c;
      end
   end

   // Scratch register with per-byte write enables.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         scratch <= SCRATCH_RESET;
      end else if (write && (address == A_SCRATCH)) begin
         for (int i = 0; i < 4; i++) begin
            if (byteenable[i])
               scratch[8*i +: 8] <= writedata[8*i +: 8];
         end
      end
   end

   // Freeze control, prescaler, uptime counter and high-word shadow.
   // Clear beats increment; a freeze written this cycle only holds from the next.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         freeze <= 1'b0;
         count  <= '0;
         presc  <= '0;
         shadow <= 32'h0;
      end else begin
         if (ctrl_wr_c)
            freeze <= writedata[1];
         if (clear_c) begin
            count <= '0;
            presc <= '0;
         end else if (!freeze) begin
            if (tick_c) begin
               count <= count + UPTIME_WIDTH'(1);
               presc <= '0;
            end else begin
               presc <= presc + PS_W'(1);
            end
         end
         if (rd_acc_c && (address == A_UP_LO))
            shadow <= 32'(count >> 32);
      end
   end

endmodule

// File: tb/tb_soc_system_sysid_ext.sv
// Directed bench for soc_system_sysid_ext: register map, scratch byte lanes,
// user words, prescaled uptime with freeze/clear, coherent 64-bit read across
// a wrap, read/write collision and asynchronous reset during a read.
module tb_soc_system_sysid_ext;

   logic        clock;
   logic        reset;
   logic [3:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;
   logic        readdatavalid;

   int checks;
   int errors;

   soc_system_sysid_ext #(
      .SCRATCH_RESET  (32'h12345678),
      .NUM_USER_WORDS (2),
      .USER_WORDS     ({192'h0, 32'h22222222, 32'h11111111}),
      .UPTIME_WIDTH   (40),
      .PRESCALE       (4)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .address       (address),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .byteenable    (byteenable),
      .readdata      (readdata),
      .readdatavalid (readdatavalid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One-cycle read; the response is checked just after the capturing edge.
   task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
      address = a;
      read    = 1'b1;
      @(posedge clock);
      #1;
      read = 1'b0;
      chk({tag, "_valid"}, 32'(readdatavalid), 32'd1);
      chk(tag, readdata, exp);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      address    = a;
      writedata  = d;
      byteenable = be;
      write      = 1'b1;
      @(posedge clock);
      #1;
      write = 1'b0;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      read       = 1'b0;
      write      = 1'b0;
      address    = 4'd0;
      writedata  = 32'h0;
      byteenable = 4'h0;

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      chk("rst_rdv", 32'(readdatavalid), 32'd0);
      chk("rst_rdata", readdata, 32'h0);
      reset = 1'b0;

      // 40 cycles after reset with PRESCALE=4 the count is 10
      repeat (40) @(posedge clock);
      #1;
      rd(4'd3, 32'd10, "uptime_lo_40");
      rd(4'd4, 32'd0, "uptime_hi_40");

      // Back-to-back fixed words, then idle hold
      rd(4'd0, 32'hACD51302, "id");
      rd(4'd1, 32'h5279E721, "timestamp");
      rd(4'd6, 32'h02040001, "capability");
      @(posedge clock);
      #1;
      chk("idle_rdv", 32'(readdatavalid), 32'd0);
      chk("idle_hold", readdata, 32'h02040001);

      // Reserved and user-word space
      rd(4'd7, 32'h0, "reserved7");
      rd(4'd8, 32'h11111111, "user0");
      rd(4'd9, 32'h22222222, "user1");
      rd(4'd10, 32'h0, "user2_absent");
      rd(4'd15, 32'h0, "user7_absent");

      // Scratch byte lanes and ignored RO writes
      rd(4'd2, 32'h12345678, "scratch_rst");
      wr(4'd2, 32'hDEADBEEF, 4'b1111);
      wr(4'd2, 32'h00000011, 4'b0001);
      rd(4'd2, 32'hDEADBE11, "scratch_be1");
      wr(4'd2, 32'hAABBCCDD, 4'b1010);
      rd(4'd2, 32'hAAADCC11, "scratch_be1010");
      wr(4'd0, 32'h0, 4'b1111);
      rd(4'd0, 32'hACD51302, "id_ro");
      wr(4'd6, 32'hFFFFFFFF, 4'b1111);
      rd(4'd6, 32'h02040001, "cap_ro");

      // Clear, freeze for 100 cycles, unfreeze resumes with held prescaler
      wr(4'd5, 32'h1, 4'b0000);
      rd(4'd3, 32'd0, "clr_lo");
      rd(4'd5, 32'h0, "ctrl_after_clr");
      wr(4'd5, 32'h2, 4'b0000);
      rd(4'd5, 32'h2, "ctrl_freeze");
      repeat (100) @(posedge clock);
      #1;
      rd(4'd3, 32'd0, "frozen_lo");
      wr(4'd5, 32'h0, 4'b0000);
      rd(4'd3, 32'd0, "unfrz_lo0");
      rd(4'd3, 32'd1, "unfrz_lo1");

      // Coherent read across a wrap of the 40-bit counter
      wr(4'd5, 32'h2, 4'b0000);
      force dut.count = 40'hFF_FFFF_FFFF;
      #1;
      release dut.count;
      rd(4'd3, 32'hFFFFFFFF, "wrap_lo");
      wr(4'd5, 32'h0, 4'b0000);
      repeat (6) @(posedge clock);
      #1;
      rd(4'd4, 32'h000000FF, "wrap_hi_shadow");
      rd(4'd3, 32'd1, "after_wrap_lo");
      rd(4'd4, 32'h0, "after_wrap_hi");

      // Read and write together: write wins, no response
      address    = 4'd2;
      writedata  = 32'h0F0F0F0F;
      byteenable = 4'b1111;
      read       = 1'b1;
      write      = 1'b1;
      @(posedge clock);
      #1;
      read  = 1'b0;
      write = 1'b0;
      chk("rw_collide_rdv", 32'(readdatavalid), 32'd0);
      rd(4'd2, 32'h0F0F0F0F, "rw_collide_scratch");

      // Asynchronous reset right after a read is accepted
      wr(4'd5, 32'h2, 4'b0000);
      address = 4'd2;
      read    = 1'b1;
      @(posedge clock);
      #1;
      read  = 1'b0;
      reset = 1'b1;
      #1;
      chk("mid_rst_rdv", 32'(readdatavalid), 32'd0);
      chk("mid_rst_rdata", readdata, 32'h0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      rd(4'd2, 32'h12345678, "post_rst_scratch");
      rd(4'd5, 32'h0, "post_rst_ctrl");
      rd(4'd3, 32'd0, "post_rst_lo");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
